imm_ctrl: RTL

ID-stage controller for the immediate extender of the 16-bit WISC-SP20 pipeline. It accepts fetched instructions over a valid/ready handshake and decodes the 5-bit opcode into the extender's select (`ext_op`) and signedness (`ext_sign`). It registers those controls with the instruction into a single-entry ID/EX holding register and manages back-pressure, flush and the HALT drain sequence. It sits between the fetch stage and the extender/execute stage.

---
 rtl/imm_ctrl_if.sv | 25 ++
 rtl/imm_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/imm_ctrl_if.sv
// Fetch-side and execute-side signals of the ID-stage immediate controller.
// The master drives the fetch instruction, flush and downstream ready.
interface imm_ctrl_if #(parameter int N = 16);
    logic         in_valid;
    logic [N-1:0] in_inst;
    logic         in_ready;
    logic         flush;
    logic         out_ready;
    logic         out_valid;
    logic [N-1:0] out_inst;
    logic         ext_sign;
    logic [1:0]   ext_op;
    logic         imm_use;
    logic         halted;

    modport master (
        output in_valid, in_inst, flush, out_ready,
        input  in_ready, out_valid, out_inst, ext_sign, ext_op, imm_use, halted
    );

    modport slave (
        input  in_valid, in_inst, flush, out_ready,
        output in_ready, out_valid, out_inst, ext_sign, ext_op, imm_use, halted
    );
endinterface

// File: rtl/imm_ctrl.sv
// ID-stage controller for the WISC-SP20 immediate extender: decodes the opcode,
// holds one instruction in the ID/EX register and sequences the HALT drain.
module imm_ctrl #(
    parameter int N = 16
) (
    input logic        clk,
    input logic        rst_n,
    imm_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [4:0] OP_HALT = 5'b00000;

    state_t       state, state_nxt;
    logic         accept, consume;
    logic         in_ready_c, halted_c;
    logic [4:0]   opcode;
    logic [1:0]   dec_op;
    logic         dec_sign, dec_use;

    logic         valid_q;
    logic [N-1:0] inst_q;
    logic         sign_q, use_q;
    logic [1:0]   op_q;

    assign opcode  = bus.in_inst[N-1 -: 5];
    assign accept  = bus.in_valid & in_ready_c;
    assign consume = valid_q & bus.out_ready;

    // NOTE: every always_comb output gets a default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        dec_op   = 2'b00;
        dec_sign = 1'b0;
        dec_use  = 1'b0;
        unique case (opcode)
            5'b01000, 5'b01001, 5'b10000, 5'b10001, 5'b10011: begin
                dec_sign = 1'b1;
                dec_use  = 1'b1;
            end
            5'b01010, 5'b01011, 5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
                dec_use  = 1'b1;
            end
            5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b11000, 5'b00101, 5'b00111: begin
                dec_op   = 2'b01;
                dec_sign = 1'b1;
                dec_use  = 1'b1;
            end
            5'b10010: begin
                dec_op   = 2'b01;
                dec_use  = 1'b1;
            end
            5'b00100, 5'b00110: begin
                dec_op   = 2'b10;
                dec_sign = 1'b1;
                dec_use  = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (accept && opcode == OP_HALT) state_nxt = DRAIN;
            DRAIN:   if (bus.flush)                   state_nxt = RUN;
                     else if (consume)                state_nxt = HALTED;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        in_ready_c = (state == RUN) & ~bus.flush & (~valid_q | bus.out_ready);
        halted_c   = (state == HALTED);
    end

    // NOTE: the holding register's data fields are reset too, since out_inst and the controls have defined reset values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            sign_q  <= 1'b0;
            op_q    <= 2'b00;
            use_q   <= 1'b0;
        end else if (bus.flush) begin
            // Squash only the valid bit; the stale controls are don't-care while invalid.
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            inst_q  <= bus.in_inst;
            sign_q  <= dec_sign;
            op_q    <= dec_op;
            use_q   <= dec_use;
        end else if (consume) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.halted    = halted_c;
    assign bus.out_valid = valid_q;
    assign bus.out_inst  = inst_q;
    assign bus.ext_sign  = sign_q;
    assign bus.ext_op    = op_q;
    assign bus.imm_use   = use_q;
endmodule
